// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: upstream pixel request/colour and DAC-side timing signals
interface vga_timing_gen_if #(
  parameter int COLOR_W = 8,
  parameter int XW = 10,
  parameter int YW = 10
);
  logic [COLOR_W-1:0] r_in, g_in, b_in;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic pix_en, frame_start, line_start;
  logic vga_clk, vga_hs, vga_vs, vga_sync_b, vga_blank_b;
  logic [COLOR_W-1:0] vga_r, vga_g, vga_b;
  modport master (
    input  r_in, g_in, b_in,
    output x, y, pix_en, frame_start, line_start,
    output vga_clk, vga_hs, vga_vs, vga_sync_b, vga_blank_b, vga_r, vga_g, vga_b
  );
  modport slave (
    output r_in, g_in, b_in,
    input  x, y, pix_en, frame_start, line_start,
    input  vga_clk, vga_hs, vga_vs, vga_sync_b, vga_blank_b, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with a one-pixel registered sync/blank/colour stage
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CLK_DIV = 2,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int COLOR_W = 8
) (
  input logic clk,
  input logic reset,
  vga_timing_gen_if.master v
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic pix_en, h_end, v_end, active, hs_raw, vs_raw;
  always_comb begin
    pix_en = div_cnt == DW'(CLK_DIV - 1);
    div_nxt = pix_en ? '0 : div_cnt + 1'b1;
    h_end = hcnt == HW'(H_TOTAL - 1);
    v_end = vcnt == VW'(V_TOTAL - 1);
    active = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    hs_raw = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  end
  assign v.pix_en = pix_en;
  assign v.x = hcnt;
  assign v.y = vcnt;
  assign v.line_start = pix_en && hcnt == '0;
  assign v.frame_start = pix_en && hcnt == '0 && vcnt == '0;
  assign v.vga_sync_b = 1'b0;
  // vga_clk follows the next divider value so it stays in phase with div_cnt
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      hcnt <= '0;
      vcnt <= '0;
      v.vga_clk <= 1'b0;
      v.vga_hs <= ~HS_POL;
      v.vga_vs <= ~VS_POL;
      v.vga_blank_b <= 1'b0;
      v.vga_r <= {COLOR_W{1'b0}};
      v.vga_g <= {COLOR_W{1'b0}};
      v.vga_b <= {COLOR_W{1'b0}};
    end else begin
      div_cnt <= div_nxt;
      v.vga_clk <= div_nxt >= DW'(CLK_DIV / 2);
      if (pix_en) begin
        hcnt <= h_end ? '0 : hcnt + 1'b1;
        if (h_end) vcnt <= v_end ? '0 : vcnt + 1'b1;
        v.vga_hs <= hs_raw ? HS_POL : ~HS_POL;
        v.vga_vs <= vs_raw ? VS_POL : ~VS_POL;
        v.vga_blank_b <= active;
        v.vga_r <= active ? v.r_in : {COLOR_W{1'b0}};
        v.vga_g <= active ? v.g_in : {COLOR_W{1'b0}};
        v.vga_b <= active ? v.b_in : {COLOR_W{1'b0}};
      end
    end
  end
endmodule
